// File: rtl/axi_dma_desc_demux.sv
// Descriptor demultiplexer: routes each descriptor to one of PORTS DMA cores by its select field,
// and merges the per-core status strobes round-robin, prefixing each tag with the core index.
module axi_dma_desc_demux #(
  parameter int PORTS             = 4,
  parameter int AXI_ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH         = 20,
  parameter int TAG_WIDTH         = 8,
  parameter int CL_PORTS          = $clog2(PORTS),
  parameter int M_TAG_WIDTH       = TAG_WIDTH + CL_PORTS,
  parameter bit AXIS_ID_ENABLE    = 1'b0,
  parameter int AXIS_ID_WIDTH     = 8,
  parameter bit AXIS_DEST_ENABLE  = 1'b0,
  parameter int AXIS_DEST_WIDTH   = 8,
  parameter bit AXIS_USER_ENABLE  = 1'b1,
  parameter int AXIS_USER_WIDTH   = 1,
  parameter int STATUS_FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [AXI_ADDR_WIDTH-1:0]            s_axis_desc_addr,
  input  logic [LEN_WIDTH-1:0]                 s_axis_desc_len,
  input  logic [TAG_WIDTH-1:0]                 s_axis_desc_tag,
  input  logic [AXIS_ID_WIDTH-1:0]             s_axis_desc_id,
  input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_desc_dest,
  input  logic [AXIS_USER_WIDTH-1:0]           s_axis_desc_user,
  input  logic [CL_PORTS-1:0]                  s_axis_desc_select,
  input  logic                                 s_axis_desc_valid,
  output logic                                 s_axis_desc_ready,

  output logic [PORTS*AXI_ADDR_WIDTH-1:0]      m_axis_desc_addr,
  output logic [PORTS*LEN_WIDTH-1:0]           m_axis_desc_len,
  output logic [PORTS*TAG_WIDTH-1:0]           m_axis_desc_tag,
  output logic [PORTS*AXIS_ID_WIDTH-1:0]       m_axis_desc_id,
  output logic [PORTS*AXIS_DEST_WIDTH-1:0]     m_axis_desc_dest,
  output logic [PORTS*AXIS_USER_WIDTH-1:0]     m_axis_desc_user,
  output logic [PORTS-1:0]                     m_axis_desc_valid,
  input  logic [PORTS-1:0]                     m_axis_desc_ready,

  input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_desc_status_len,
  input  logic [PORTS*TAG_WIDTH-1:0]           s_axis_desc_status_tag,
  input  logic [PORTS*AXIS_ID_WIDTH-1:0]       s_axis_desc_status_id,
  input  logic [PORTS*AXIS_DEST_WIDTH-1:0]     s_axis_desc_status_dest,
  input  logic [PORTS*AXIS_USER_WIDTH-1:0]     s_axis_desc_status_user,
  input  logic [PORTS*4-1:0]                   s_axis_desc_status_error,
  input  logic [PORTS-1:0]                     s_axis_desc_status_valid,

  output logic [LEN_WIDTH-1:0]                 m_axis_desc_status_len,
  output logic [M_TAG_WIDTH-1:0]               m_axis_desc_status_tag,
  output logic [AXIS_ID_WIDTH-1:0]             m_axis_desc_status_id,
  output logic [AXIS_DEST_WIDTH-1:0]           m_axis_desc_status_dest,
  output logic [AXIS_USER_WIDTH-1:0]           m_axis_desc_status_user,
  output logic [3:0]                           m_axis_desc_status_error,
  output logic                                 m_axis_desc_status_valid,

  output logic                                 select_error,
  output logic [PORTS-1:0]                     status_overflow
);

  localparam int AW = $clog2(STATUS_FIFO_DEPTH);

  if (PORTS < 2) begin : g_chk_ports
    $error("axi_dma_desc_demux: PORTS must be at least 2");
  end
  if (CL_PORTS != $clog2(PORTS)) begin : g_chk_cl
    $error("axi_dma_desc_demux: CL_PORTS must not be overridden");
  end
  if (STATUS_FIFO_DEPTH < 2 || (STATUS_FIFO_DEPTH != (1 << AW))) begin : g_chk_depth
    $error("axi_dma_desc_demux: STATUS_FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]       len;
    logic [TAG_WIDTH-1:0]       tag;
    logic [AXIS_ID_WIDTH-1:0]   id;
    logic [AXIS_DEST_WIDTH-1:0] dest;
    logic [AXIS_USER_WIDTH-1:0] user;
  } desc_t;

  typedef struct packed {
    logic [LEN_WIDTH-1:0]       len;
    logic [TAG_WIDTH-1:0]       tag;
    logic [AXIS_ID_WIDTH-1:0]   id;
    logic [AXIS_DEST_WIDTH-1:0] dest;
    logic [AXIS_USER_WIDTH-1:0] user;
    logic [3:0]                 error;
  } stat_t;

  desc_t              s_desc;
  desc_t              desc_p1, desc_skid_p1;
  logic [PORTS-1:0]   vld_p1, vld_skid_p1;
  logic [PORTS-1:0]   vld_next, vld_skid_next, sel_onehot, in_vec;
  logic               sel_ok, in_vld, out_ready, ready_early;
  logic               load_in_out, load_in_skid, load_skid_out;

  assign s_desc = {s_axis_desc_addr, s_axis_desc_len, s_axis_desc_tag,
                   s_axis_desc_id, s_axis_desc_dest, s_axis_desc_user};

  // Out-of-range selects exist only when PORTS is not a power of two.
  if (PORTS == (1 << CL_PORTS)) begin : g_sel_pow2
    assign sel_ok = 1'b1;
  end else begin : g_sel_npow2
    assign sel_ok = s_axis_desc_select < CL_PORTS'(PORTS);
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) sel_onehot[i] = (s_axis_desc_select == CL_PORTS'(i));
    in_vld        = s_axis_desc_valid && s_axis_desc_ready && sel_ok;
    in_vec        = in_vld ? sel_onehot : '0;
    out_ready     = |(m_axis_desc_ready & vld_p1);
    ready_early   = out_ready || (!(|vld_skid_p1) && (!(|vld_p1) || !in_vld));
    vld_next      = vld_p1;
    vld_skid_next = vld_skid_p1;
    load_in_out   = 1'b0;
    load_in_skid  = 1'b0;
    load_skid_out = 1'b0;
    if (s_axis_desc_ready) begin
      if (out_ready || !(|vld_p1)) begin
        vld_next    = in_vec;
        load_in_out = 1'b1;
      end else begin
        vld_skid_next = in_vec;
        load_in_skid  = 1'b1;
      end
    end else if (out_ready) begin
      vld_next      = vld_skid_p1;
      vld_skid_next = '0;
      load_skid_out = 1'b1;
    end
  end

  // Stage p1: output register plus skid register
  always_ff @(posedge clk) begin
    if (load_in_out)        desc_p1 <= s_desc;
    else if (load_skid_out) desc_p1 <= desc_skid_p1;
    if (load_in_skid)       desc_skid_p1 <= s_desc;
    if (rst) begin
      vld_p1            <= '0;
      vld_skid_p1       <= '0;
      s_axis_desc_ready <= 1'b0;
      select_error      <= 1'b0;
    end else begin
      vld_p1            <= vld_next;
      vld_skid_p1       <= vld_skid_next;
      s_axis_desc_ready <= ready_early;
      select_error      <= s_axis_desc_valid && s_axis_desc_ready && !sel_ok;
    end
  end

  assign m_axis_desc_valid = vld_p1;
  assign m_axis_desc_addr  = {PORTS{desc_p1.addr}};
  assign m_axis_desc_len   = {PORTS{desc_p1.len}};
  assign m_axis_desc_tag   = {PORTS{desc_p1.tag}};
  assign m_axis_desc_id    = AXIS_ID_ENABLE   ? {PORTS{desc_p1.id}}   : '0;
  assign m_axis_desc_dest  = AXIS_DEST_ENABLE ? {PORTS{desc_p1.dest}} : '0;
  assign m_axis_desc_user  = AXIS_USER_ENABLE ? {PORTS{desc_p1.user}} : '0;

  stat_t              fifo_head [PORTS];
  logic [PORTS-1:0]   fifo_empty, pop;
  logic [2*PORTS-1:0] req2;
  logic [CL_PORTS-1:0] rr_ptr, grant, rr_next;
  logic               grant_vld;
  stat_t              head_sel, stat_p1;
  logic [CL_PORTS-1:0] stat_idx_p1;
  logic               stat_vld_p1;

  for (genvar i = 0; i < PORTS; i++) begin : g_fifo
    stat_t        mem [STATUS_FIFO_DEPTH];
    stat_t        in_entry;
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         full, wr, ovf;

    assign in_entry = {s_axis_desc_status_len[i*LEN_WIDTH +: LEN_WIDTH],
                       s_axis_desc_status_tag[i*TAG_WIDTH +: TAG_WIDTH],
                       s_axis_desc_status_id[i*AXIS_ID_WIDTH +: AXIS_ID_WIDTH],
                       s_axis_desc_status_dest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH],
                       s_axis_desc_status_user[i*AXIS_USER_WIDTH +: AXIS_USER_WIDTH],
                       s_axis_desc_status_error[i*4 +: 4]};
    assign fifo_empty[i]      = (wr_ptr == rd_ptr);
    assign full               = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    // A full FIFO still accepts a write in the same cycle it is popped.
    assign wr                 = s_axis_desc_status_valid[i] && (!full || pop[i]);
    assign fifo_head[i]       = mem[rd_ptr[AW-1:0]];
    assign status_overflow[i] = ovf;

    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= in_entry;
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        if (wr)     wr_ptr <= wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
        if (s_axis_desc_status_valid[i] && full && !pop[i]) ovf <= 1'b1;
      end
    end
  end

  // Round-robin search over a doubled request vector starting at rr_ptr.
  always_comb begin
    req2      = {~fifo_empty, ~fifo_empty};
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < 2*PORTS; k++) begin
      if (!grant_vld && k >= int'(rr_ptr) && k < int'(rr_ptr) + PORTS && req2[k]) begin
        grant_vld = 1'b1;
        grant     = (k >= PORTS) ? CL_PORTS'(k - PORTS) : CL_PORTS'(k);
      end
    end
    rr_next  = (grant == CL_PORTS'(PORTS-1)) ? '0 : grant + 1'b1;
    pop      = '0;
    head_sel = fifo_head[0];
    for (int i = 0; i < PORTS; i++) begin
      if (grant_vld && grant == CL_PORTS'(i)) begin
        pop[i]   = 1'b1;
        head_sel = fifo_head[i];
      end
    end
  end

  // Stage p1: merged status output register
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      stat_p1     <= head_sel;
      stat_idx_p1 <= grant;
    end
    if (rst) begin
      stat_vld_p1 <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      stat_vld_p1 <= grant_vld;
      if (grant_vld) rr_ptr <= rr_next;
    end
  end

  assign m_axis_desc_status_valid = stat_vld_p1;
  assign m_axis_desc_status_len   = stat_p1.len;
  assign m_axis_desc_status_tag   = {stat_idx_p1, stat_p1.tag};
  assign m_axis_desc_status_id    = AXIS_ID_ENABLE   ? stat_p1.id   : '0;
  assign m_axis_desc_status_dest  = AXIS_DEST_ENABLE ? stat_p1.dest : '0;
  assign m_axis_desc_status_user  = AXIS_USER_ENABLE ? stat_p1.user : '0;
  assign m_axis_desc_status_error = stat_p1.error;

endmodule

// File: tb/tb_axi_dma_desc_demux.sv
// Directed bench for axi_dma_desc_demux: a 4-port instance for routing, skid, status merge and
// overflow, plus a 3-port instance for out-of-range select handling.
module tb_axi_dma_desc_demux;
  localparam int P = 4, AW = 16, LW = 20, TW = 8, CL = 2, MTW = 10, IW = 8, DW = 8, UW = 1;
  localparam int P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_len;
  logic [TW-1:0] s_tag;
  logic [IW-1:0] s_id;
  logic [DW-1:0] s_dest;
  logic [UW-1:0] s_user;
  logic [CL-1:0] s_sel, s_sel3;
  logic          s_valid, s_ready, s_valid3, s_ready3;

  logic [P*AW-1:0] m_addr;
  logic [P*LW-1:0] m_len;
  logic [P*TW-1:0] m_tag;
  logic [P*IW-1:0] m_id;
  logic [P*DW-1:0] m_dest;
  logic [P*UW-1:0] m_user;
  logic [P-1:0]    m_valid, m_ready;

  logic [P*LW-1:0] st_len;
  logic [P*TW-1:0] st_tag;
  logic [P*IW-1:0] st_id;
  logic [P*DW-1:0] st_dest;
  logic [P*UW-1:0] st_user;
  logic [P*4-1:0]  st_error;
  logic [P-1:0]    st_valid;

  logic [LW-1:0]  ms_len;
  logic [MTW-1:0] ms_tag;
  logic [IW-1:0]  ms_id;
  logic [DW-1:0]  ms_dest;
  logic [UW-1:0]  ms_user;
  logic [3:0]     ms_error;
  logic           ms_valid, sel_err;
  logic [P-1:0]   ovf;

  logic [P3*AW-1:0] m3_addr;
  logic [P3*LW-1:0] m3_len;
  logic [P3*TW-1:0] m3_tag;
  logic [P3*IW-1:0] m3_id;
  logic [P3*DW-1:0] m3_dest;
  logic [P3*UW-1:0] m3_user;
  logic [P3-1:0]    m3_valid, m3_ready, ovf3;
  logic [LW-1:0]    ms3_len;
  logic [MTW-1:0]   ms3_tag;
  logic [IW-1:0]    ms3_id;
  logic [DW-1:0]    ms3_dest;
  logic [UW-1:0]    ms3_user;
  logic [3:0]       ms3_error;
  logic             ms3_valid, sel_err3;

  axi_dma_desc_demux #(.PORTS(P)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_desc_addr(s_addr), .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
    .s_axis_desc_id(s_id), .s_axis_desc_dest(s_dest), .s_axis_desc_user(s_user),
    .s_axis_desc_select(s_sel), .s_axis_desc_valid(s_valid), .s_axis_desc_ready(s_ready),
    .m_axis_desc_addr(m_addr), .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
    .m_axis_desc_id(m_id), .m_axis_desc_dest(m_dest), .m_axis_desc_user(m_user),
    .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
    .s_axis_desc_status_len(st_len), .s_axis_desc_status_tag(st_tag),
    .s_axis_desc_status_id(st_id), .s_axis_desc_status_dest(st_dest),
    .s_axis_desc_status_user(st_user), .s_axis_desc_status_error(st_error),
    .s_axis_desc_status_valid(st_valid),
    .m_axis_desc_status_len(ms_len), .m_axis_desc_status_tag(ms_tag),
    .m_axis_desc_status_id(ms_id), .m_axis_desc_status_dest(ms_dest),
    .m_axis_desc_status_user(ms_user), .m_axis_desc_status_error(ms_error),
    .m_axis_desc_status_valid(ms_valid),
    .select_error(sel_err), .status_overflow(ovf)
  );

  axi_dma_desc_demux #(.PORTS(P3)) u_dut3 (
    .clk(clk), .rst(rst),
    .s_axis_desc_addr(s_addr), .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
    .s_axis_desc_id(s_id), .s_axis_desc_dest(s_dest), .s_axis_desc_user(s_user),
    .s_axis_desc_select(s_sel3), .s_axis_desc_valid(s_valid3), .s_axis_desc_ready(s_ready3),
    .m_axis_desc_addr(m3_addr), .m_axis_desc_len(m3_len), .m_axis_desc_tag(m3_tag),
    .m_axis_desc_id(m3_id), .m_axis_desc_dest(m3_dest), .m_axis_desc_user(m3_user),
    .m_axis_desc_valid(m3_valid), .m_axis_desc_ready(m3_ready),
    .s_axis_desc_status_len('0), .s_axis_desc_status_tag('0),
    .s_axis_desc_status_id('0), .s_axis_desc_status_dest('0),
    .s_axis_desc_status_user('0), .s_axis_desc_status_error('0),
    .s_axis_desc_status_valid('0),
    .m_axis_desc_status_len(ms3_len), .m_axis_desc_status_tag(ms3_tag),
    .m_axis_desc_status_id(ms3_id), .m_axis_desc_status_dest(ms3_dest),
    .m_axis_desc_status_user(ms3_user), .m_axis_desc_status_error(ms3_error),
    .m_axis_desc_status_valid(ms3_valid),
    .select_error(sel_err3), .status_overflow(ovf3)
  );

  // Delivered-descriptor log and merged-status counters
  logic [AW-1:0] dq_addr [$];
  int            dq_port [$];
  int            st_cnt = 0;
  int            st_port_cnt [P];

  always @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (m_valid[i] && m_ready[i]) begin
        dq_addr.push_back(m_addr[i*AW +: AW]);
        dq_port.push_back(i);
      end
    end
    if (ms_valid) begin
      st_cnt++;
      st_port_cnt[ms_tag[MTW-1 -: CL]]++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int n0, c0;
  int pc0 [P];

  initial begin
    rst = 1'b1;
    s_valid = 0; s_valid3 = 0; s_sel = '0; s_sel3 = '0;
    s_addr = '0; s_len = '0; s_tag = '0; s_id = '0; s_dest = '0; s_user = '0;
    m_ready = '1; m3_ready = '1;
    st_len = '0; st_tag = '0; st_id = '0; st_dest = '0; st_user = '0; st_error = '0; st_valid = '0;
    repeat (3) tick();

    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_status_valid", ms_valid, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_select_error", sel_err, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", s_ready, 1);

    // Single descriptor to port 2
    s_valid = 1; s_sel = 2; s_addr = 16'h1000; s_len = 20'd64; s_tag = 8'h5A;
    s_id = 8'h77; s_user = 1'b1;
    n0 = dq_addr.size();
    tick();
    s_valid = 0;
    chk("route_valid", m_valid, 4'b0100);
    chk("route_addr", m_addr[2*AW +: AW], 16'h1000);
    chk("route_len", m_len[2*LW +: LW], 64);
    chk("route_tag", m_tag[2*TW +: TW], 8'h5A);
    chk("route_addr_shared", m_addr[0 +: AW], 16'h1000);
    chk("route_user", m_user[2], 1);
    chk("route_id_disabled", m_id, 0);
    chk("route_ready_stays", s_ready, 1);
    tick();
    chk("route_done", m_valid, 0);
    chk("route_delivered_cnt", dq_addr.size() - n0, 1);
    chk("route_delivered_port", dq_port[n0], 2);

    // Back-to-back descriptors to different ports
    s_valid = 1; s_sel = 0; s_addr = 16'hA000;
    tick();
    chk("b2b_first", m_valid, 4'b0001);
    s_sel = 3; s_addr = 16'hB000;
    tick();
    s_valid = 0;
    chk("b2b_second", m_valid, 4'b1000);
    chk("b2b_second_addr", m_addr[3*AW +: AW], 16'hB000);
    tick();
    chk("b2b_idle", m_valid, 0);

    // Port 1 stalled: two descriptors buffered, third held off until ready returns
    m_ready = 4'b1101;
    n0 = dq_addr.size();
    s_valid = 1; s_sel = 1; s_addr = 16'h0A00;
    tick();
    chk("hol_ready_1", s_ready, 1);
    chk("hol_valid_1", m_valid, 4'b0010);
    s_addr = 16'h0A01;
    tick();
    chk("hol_ready_2", s_ready, 0);
    s_addr = 16'h0A02;
    tick();
    tick();
    tick();
    chk("hol_ready_held", s_ready, 0);
    chk("hol_head_addr", m_addr[1*AW +: AW], 16'h0A00);
    m_ready = 4'b1111;
    tick();
    chk("hol_skid_out", m_addr[1*AW +: AW], 16'h0A01);
    chk("hol_ready_back", s_ready, 1);
    tick();
    s_valid = 0;
    chk("hol_third_out", m_addr[1*AW +: AW], 16'h0A02);
    tick();
    chk("hol_drained", m_valid, 0);
    chk("hol_count", dq_addr.size() - n0, 3);
    chk("hol_order_0", dq_addr[n0], 16'h0A00);
    chk("hol_order_1", dq_addr[n0+1], 16'h0A01);
    chk("hol_order_2", dq_addr[n0+2], 16'h0A02);

    // 3-port instance: select 3 is consumed and flagged, select 2 is routed
    s_valid3 = 1; s_sel3 = 3;
    tick();
    s_valid3 = 0;
    chk("sel3_no_valid", m3_valid, 0);
    chk("sel3_error_pulse", sel_err3, 1);
    chk("sel3_ready", s_ready3, 1);
    tick();
    chk("sel3_error_clear", sel_err3, 0);
    s_valid3 = 1; s_sel3 = 2;
    tick();
    s_valid3 = 0;
    chk("sel3_port2", m3_valid, 3'b100);
    chk("sel3_no_error", sel_err3, 0);

    // Simultaneous status strobes on ports 0, 1, 3
    do_reset();
    st_tag[0*TW +: TW] = 8'h11; st_tag[1*TW +: TW] = 8'h22; st_tag[3*TW +: TW] = 8'h33;
    st_len[0*LW +: LW] = 20'd5; st_error[0*4 +: 4] = 4'h3;
    st_valid = 4'b1011;
    tick();
    st_valid = '0;
    chk("stat_not_yet", ms_valid, 0);
    tick();
    chk("stat_0_valid", ms_valid, 1);
    chk("stat_0_tag", ms_tag, 10'h011);
    chk("stat_0_len", ms_len, 5);
    chk("stat_0_error", ms_error, 4'h3);
    tick();
    chk("stat_1_tag", ms_tag, 10'h122);
    tick();
    chk("stat_2_tag", ms_tag, 10'h333);
    chk("stat_2_valid", ms_valid, 1);
    tick();
    chk("stat_end", ms_valid, 0);

    // Ports 0, 1, 2 strobe together for 5 cycles: nothing dropped at depth 4
    do_reset();
    c0 = st_cnt;
    for (int i = 0; i < P; i++) pc0[i] = st_port_cnt[i];
    st_valid = 4'b0111;
    repeat (5) tick();
    st_valid = '0;
    repeat (20) tick();
    chk("contend_total", st_cnt - c0, 15);
    chk("contend_port0", st_port_cnt[0] - pc0[0], 5);
    chk("contend_port2", st_port_cnt[2] - pc0[2], 5);
    chk("contend_no_ovf", ovf, 0);

    // All four ports strobe for 6 cycles: ports 1-3 drop one entry each
    do_reset();
    c0 = st_cnt;
    st_valid = 4'b1111;
    repeat (6) tick();
    st_valid = '0;
    repeat (30) tick();
    chk("ovf_total", st_cnt - c0, 21);
    chk("ovf_flags", ovf, 4'b1110);
    rst = 1'b1;
    tick();
    chk("ovf_cleared", ovf, 0);
    rst = 1'b0;
    tick();

    // Reset with output and skid registers both full
    m_ready = '0;
    n0 = dq_addr.size();
    s_valid = 1; s_sel = 0; s_addr = 16'hC000;
    tick();
    s_addr = 16'hC001;
    tick();
    s_valid = 0;
    chk("skid_full_ready", s_ready, 0);
    rst = 1'b1;
    tick();
    chk("midrst_valid", m_valid, 0);
    chk("midrst_ready", s_ready, 0);
    rst = 1'b0;
    m_ready = '1;
    tick();
    chk("midrst_ready_back", s_ready, 1);
    s_valid = 1; s_sel = 3; s_addr = 16'hD000;
    tick();
    s_valid = 0;
    chk("resume_valid", m_valid, 4'b1000);
    chk("resume_addr", m_addr[3*AW +: AW], 16'hD000);
    tick();
    chk("resume_count", dq_addr.size() - n0, 1);
    chk("resume_last_addr", dq_addr[dq_addr.size()-1], 16'hD000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
